mem_io_port: RTL

Memory-mapped I/O responder on the processor's data-memory bus, alongside `mem_data`. It decodes a 16-word address window; a write there pushes 32-bit words into a transmit FIFO that drains over a valid/ready stream. It also holds one inbound word captured from an external valid/ready stream, which the processor reads back. The top level steers the processor's read data from `io_rdata` whenever `io_sel` is high.

---
 rtl/mem_io_port_pkg.sv | 19 +
 rtl/mem_io_port_sync_fifo.sv | 56 +++++
 rtl/mem_io_port.sv | 134 +++++++++++++
 3 files changed

// File: rtl/mem_io_port_pkg.sv
// Shared constants for mem_io_port: register offsets inside the 16-word window
// and bit positions of the STATUS register.
package mem_io_port_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_RXDATA = 4'd2;
  localparam logic [3:0] OFF_RXACK  = 4'd3;
  localparam logic [3:0] OFF_CTRL   = 4'd4;
  localparam logic [3:0] OFF_OVF    = 4'd5;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_TX_EN    = 3;
  localparam int ST_LVL_LSB  = 8;
  localparam int ST_LVL_MSB  = 12;

endpackage

// File: rtl/mem_io_port_sync_fifo.sv
// Single-clock FIFO with a combinational head; a push while full is accepted
// only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level,
  output logic [WIDTH-1:0] head
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage has no reset; the level counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/mem_io_port.sv
// Memory-mapped I/O responder: TX FIFO fed by bus writes, one-word RX holding
// register, 1-cycle registered read path. Optional overflow counter: MEM_IO_PORT_OVF_CNT_EN.
module mem_io_port
  import mem_io_port_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR  = 8'hF0,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic [7:0]  mem_addr,
  input  logic [31:0] mem_data_out,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          hit;
  logic [3:0]    off;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_full;
  logic          tx_empty;
  logic [LW-1:0] tx_level;
  logic [4:0]    level_ext;
  logic          tx_en;
  logic          rx_full;
  logic [31:0]   rx_word;
  logic [31:0]   ovf_rd;
  logic [31:0]   rd_next;

  assign hit       = (mem_addr[7:4] == BASE_ADDR[7:4]);
  assign off       = mem_addr[3:0];
  assign tx_push   = mem_wr && hit && (off == OFF_TXDATA);
  assign tx_valid  = !tx_empty && tx_en;
  assign tx_pop    = tx_valid && tx_ready;
  assign rx_ready  = !rx_full;
  assign level_ext = 5'(tx_level);

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (mem_data_out),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level),
    .head  (tx_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_en <= 1'b0;
    end else if (mem_wr && hit && (off == OFF_CTRL)) begin
      tx_en <= mem_data_out[0];
    end
  end

  // A capture takes priority over an RXACK landing on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_full <= 1'b0;
      rx_word <= '0;
    end else if (rx_valid && !rx_full) begin
      rx_full <= 1'b1;
      rx_word <= rx_data;
    end else if (mem_wr && hit && (off == OFF_RXACK)) begin
      rx_full <= 1'b0;
    end
  end

`ifdef MEM_IO_PORT_OVF_CNT_EN
  logic [7:0] ovf_cnt;
  logic       tx_drop;

  assign tx_drop = tx_push && tx_full && !tx_pop;
  assign ovf_rd  = 32'(ovf_cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_cnt <= '0;
    end else if (mem_wr && hit && (off == OFF_OVF)) begin
      ovf_cnt <= '0;
    end else if (tx_drop && (ovf_cnt != 8'hFF)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end
`else
  assign ovf_rd = '0;
`endif

  // NOTE: rd_next gets its default before the case so no latch is inferred.
  always_comb begin
    rd_next = '0;
    if (hit) begin
      case (off)
        OFF_STATUS: begin
          rd_next[ST_TX_FULL]             = tx_full;
          rd_next[ST_TX_EMPTY]            = tx_empty;
          rd_next[ST_RX_FULL]             = rx_full;
          rd_next[ST_TX_EN]               = tx_en;
          rd_next[ST_LVL_MSB:ST_LVL_LSB]  = level_ext;
        end
        OFF_RXDATA: rd_next = rx_word;
        OFF_CTRL:   rd_next = {31'b0, tx_en};
        OFF_OVF:    rd_next = ovf_rd;
        default:    rd_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      io_sel   <= 1'b0;
      io_rdata <= '0;
    end else begin
      io_sel   <= hit;
      io_rdata <= rd_next;
    end
  end

endmodule
